// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose
//   Lets two requesters share the single-port RAM of the multicycle core.
//   Port 0 is the CPU control path and port 1 is the DMA/loader.
//   Accesses are serialised: one winner is captured per IDLE cycle, the RAM
//   strobe is held for MEM_LAT cycles, and a dead RECOVER cycle follows.
//   The RECOVER cycle gives the requester time to drop REQ after DONE.
//   Every output comes straight from a flop.
//
// Parameters
//   ADDR_W   RAM address width
//   DATA_W   RAM data width
//   MEM_LAT  number of cycles the strobe is held per access (>= 1)
//
// Ports
//   i_clk, i_rst_n          clock (rising edge), async active-low reset
//   i_req0/1                access request, held until the matching DONE
//   i_we0/1                 1 = write, 0 = read
//   i_addr0/1, i_wdata0/1   access address and write data
//   o_gnt0/1                one-cycle pulse: request accepted, inputs captured
//   o_done0/1               one-cycle pulse: access complete
//   o_rdata                 read data, held until the next read completes
//   o_mem_addr, o_mem_din   RAM address and write data
//   o_mem_ws, o_mem_oe      RAM write strobe and output enable
//   i_mem_dout              RAM read data
//   o_busy                  high whenever the arbiter is not in IDLE
//
// Build option
//   CPU_PRIORITY_EN  When defined, port 0 always wins a tie (the DMA may starve).
//                    When undefined (default), ties are broken round-robin.
// ---------------------------------------------------------------------------
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | no access in flight; arbitrate at the next edge
// ST_ACCESS  | strobe active for MEM_LAT cycles, counted by r_cnt
// ST_RECOVER | dead cycle after DONE; strobes low and no grant
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic              i_we0,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic              o_gnt0,
    output logic              o_gnt1,
    output logic              o_done0,
    output logic              o_done1,
    output logic [DATA_W-1:0] o_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_din,
    output logic              o_mem_ws,
    output logic              o_mem_oe,
    input  logic [DATA_W-1:0] i_mem_dout,
    output logic              o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    localparam int               CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

    state_t              r_state,    w_state;
    logic [CNT_W-1:0]    r_cnt,      w_cnt;
    logic                r_owner,    w_owner;
    logic                r_gnt0,     w_gnt0;
    logic                r_gnt1,     w_gnt1;
    logic                r_done0,    w_done0;
    logic                r_done1,    w_done1;
    logic [DATA_W-1:0]   r_rdata,    w_rdata;
    logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr;
    logic [DATA_W-1:0]   r_mem_din,  w_mem_din;
    logic                r_mem_ws,   w_mem_ws;
    logic                r_mem_oe,   w_mem_oe;
    logic                r_busy,     w_busy;

    logic                w_any_req;
    logic                w_winner;
    logic                w_win_we;

`ifndef CPU_PRIORITY_EN
    logic                r_last,     w_last;
`endif

    assign w_any_req = i_req0 | i_req1;

    // Winner is only meaningful when w_any_req is set. A lone request wins
    // outright; a tie is resolved by the selected policy.
`ifdef CPU_PRIORITY_EN
    assign w_winner = ~i_req0;
`else
    assign w_winner = (i_req0 & i_req1) ? ~r_last : i_req1;
`endif

    assign w_win_we = w_winner ? i_we1 : i_we0;

    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_owner    = r_owner;
        w_gnt0     = 1'b0;
        w_gnt1     = 1'b0;
        w_done0    = 1'b0;
        w_done1    = 1'b0;
        w_rdata    = r_rdata;
        w_mem_addr = r_mem_addr;
        w_mem_din  = r_mem_din;
        w_mem_ws   = r_mem_ws;
        w_mem_oe   = r_mem_oe;
`ifndef CPU_PRIORITY_EN
        w_last     = r_last;
`endif

        case (r_state)
            ST_IDLE: begin
                w_mem_ws = 1'b0;
                w_mem_oe = 1'b0;
                if (w_any_req) begin
                    w_owner    = w_winner;
                    w_mem_addr = w_winner ? i_addr1  : i_addr0;
                    w_mem_din  = w_winner ? i_wdata1 : i_wdata0;
                    w_mem_ws   = w_win_we;
                    w_mem_oe   = ~w_win_we;
                    w_gnt0     = ~w_winner;
                    w_gnt1     = w_winner;
                    w_cnt      = '0;
                    w_state    = ST_ACCESS;
`ifndef CPU_PRIORITY_EN
                    w_last     = w_winner;
`endif
                end
            end

            ST_ACCESS: begin
                w_cnt = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_LAST) begin
                    // r_mem_oe still marks a read here; sample the RAM in the
                    // last strobe cycle.
                    if (r_mem_oe) begin
                        w_rdata = i_mem_dout;
                    end
                    w_mem_ws = 1'b0;
                    w_mem_oe = 1'b0;
                    w_done0  = ~r_owner;
                    w_done1  = r_owner;
                    w_cnt    = '0;
                    w_state  = ST_RECOVER;
                end
            end

            ST_RECOVER: begin
                w_mem_ws = 1'b0;
                w_mem_oe = 1'b0;
                w_state  = ST_IDLE;
            end

            default: begin
                w_mem_ws = 1'b0;
                w_mem_oe = 1'b0;
                w_state  = ST_IDLE;
            end
        endcase

        w_busy = (w_state != ST_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_owner    <= 1'b0;
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_done0    <= 1'b0;
            r_done1    <= 1'b0;
            r_rdata    <= '0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_mem_ws   <= 1'b0;
            r_mem_oe   <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_owner    <= w_owner;
            r_gnt0     <= w_gnt0;
            r_gnt1     <= w_gnt1;
            r_done0    <= w_done0;
            r_done1    <= w_done1;
            r_rdata    <= w_rdata;
            r_mem_addr <= w_mem_addr;
            r_mem_din  <= w_mem_din;
            r_mem_ws   <= w_mem_ws;
            r_mem_oe   <= w_mem_oe;
            r_busy     <= w_busy;
        end
    end

`ifndef CPU_PRIORITY_EN
    // Reset value 1 makes the CPU win the first tie.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last <= 1'b1;
        end else begin
            r_last <= w_last;
        end
    end
`endif

    assign o_gnt0     = r_gnt0;
    assign o_gnt1     = r_gnt1;
    assign o_done0    = r_done0;
    assign o_done1    = r_done1;
    assign o_rdata    = r_rdata;
    assign o_mem_addr = r_mem_addr;
    assign o_mem_din  = r_mem_din;
    assign o_mem_ws   = r_mem_ws;
    assign o_mem_oe   = r_mem_oe;
    assign o_busy     = r_busy;

endmodule
